// File: rtl/data_mem_if.sv
// Load/store port between the core (master) and a data memory responder (slave).
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: one request at a time, WAIT_CYCLES wait states,
// byte/half/word loads with extension and byte-lane stores.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    data_mem_if.slave   bus,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [31:0]     rdata_q, rdata_n;
    logic            err_q, err_n;
    logic            accept, commit;

    logic            wr_q, bad_q;
    logic [2:0]      size_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [AW-1:0]   idx;
    logic [31:0]     word;
    logic [31:0]     mem [DEPTH_WORDS];

    function automatic logic req_bad(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        logic illegal, misaligned;
        illegal    = wr ? (sz > 3'd2) : (sz == 3'd3 || sz == 3'd6 || sz == 3'd7);
        misaligned = (sz[1:0] == 2'd1 && a[0]) || (sz[1:0] == 2'd2 && a[1:0] != 2'd0);
        return illegal || misaligned || (a >= LIMIT);
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] sz,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] w;
        w = old;
        case (sz)
            2'd0:    w[{a, 3'b000} +: 8] = wd[7:0];
            2'd1:    w[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: w = wd;
        endcase
        return w;
    endfunction

    assign accept = (state == IDLE) && bus.req_valid;
    assign idx    = addr_q[AW+1:2];
    assign word   = mem[idx];

    // Every accepted request passes through WAIT; rejected ones leave it on the next edge,
    // good ones after WAIT_CYCLES further edges, giving latency 1+WAIT_CYCLES.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rdata_n = rdata_q;
        err_n   = err_q;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_n = WAIT;
                    cnt_n   = req_bad(bus.req_write, bus.req_size, bus.req_addr)
                              ? '0 : CW'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = RESP;
                    err_n   = bad_q;
                    rdata_n = (bad_q || wr_q) ? 32'd0 : load_ext(word, size_q, addr_q[1:0]);
                    commit  = !bad_q && wr_q;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_n = IDLE;
                    rdata_n = 32'd0;
                    err_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.req_write;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr[AW+1:0];
            wdata_q <= bus.req_wdata;
            bad_q   <= req_bad(bus.req_write, bus.req_size, bus.req_addr);
        end
    end

    // Storage is never reset; commit only fires in WAIT, which reset leaves immediately.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx] <= store_merge(word, wdata_q, size_q[1:0], addr_q[1:0]);
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset/hold corner sequences and
// randomized traffic against a byte-array reference model, for WAIT_CYCLES of 2 and 0.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_write, rsp_ready;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy2, busy0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_if bus2();
    data_mem_if bus0();

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .busy(busy2));
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0));

    assign bus2.req_valid = req_valid & ~sel;
    assign bus0.req_valid = req_valid & sel;
    assign bus2.rsp_ready = rsp_ready & ~sel;
    assign bus0.rsp_ready = rsp_ready & sel;
    assign bus2.req_write = req_write;
    assign bus0.req_write = req_write;
    assign bus2.req_addr  = req_addr;
    assign bus0.req_addr  = req_addr;
    assign bus2.req_size  = req_size;
    assign bus0.req_size  = req_size;
    assign bus2.req_wdata = req_wdata;
    assign bus0.req_wdata = req_wdata;

    logic        m_req_ready, m_rsp_valid, m_rsp_err, m_busy;
    logic [31:0] m_rsp_rdata;
    assign m_req_ready = sel ? bus0.req_ready : bus2.req_ready;
    assign m_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
    assign m_rsp_err   = sel ? bus0.rsp_err   : bus2.rsp_err;
    assign m_rsp_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
    assign m_busy      = sel ? busy0 : busy2;

    // Reference memory: one byte array per instance.
    logic [7:0] ref_mem [2][1024];

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t vt[20];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_rsp_valid"}, 32'(m_rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, m_rsp_rdata, 32'd0);
        check({tag, "_rsp_err"},   32'(m_rsp_err), 32'd0);
        check({tag, "_busy"},      32'(m_busy), 32'd0);
        check({tag, "_req_ready"}, 32'(m_req_ready), 32'd1);
    endtask

    task automatic model(input int s, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n;
        logic illegal;
        logic [31:0] v;
        n = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        illegal = wr ? (sz > 3'd2) : (sz == 3'd3 || sz == 3'd6 || sz == 3'd7);
        er = illegal || (a % n != 0) || (a >= 32'd1024);
        rd = 32'd0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < n; i++) ref_mem[s][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[s][int'(a) + i]) << (8*i));
                if (!sz[2] && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
                rd = v;
            end
        end
    endtask

    function automatic int exp_lat(input int s, input logic er);
        return er ? 1 : 1 + ((s == 0) ? 2 : 0);
    endfunction

    task automatic txn(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input logic early, input int lat_exp,
                       output logic [31:0] rd, output logic er);
        int  lat;
        bit  seen;
        @(negedge clk);
        check("req_ready_before", 32'(m_req_ready), 32'd1);
        req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~wr; req_size = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        rsp_ready = early;
        check("busy_after_accept", 32'(m_busy), 32'd1);
        check("req_ready_after_accept", 32'(m_req_ready), 32'd0);
        lat = 0; seen = 0;
        while (!seen && lat < 20) begin
            if (m_rsp_valid) seen = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check("latency", 32'(lat), 32'(lat_exp));
        rd = m_rsp_rdata;
        er = m_rsp_err;
        if (seen) begin
            if (hold > 0) rsp_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_rsp_valid", 32'(m_rsp_valid), 32'd1);
                check("hold_rsp_rdata", m_rsp_rdata, rd);
                check("hold_rsp_err",   32'(m_rsp_err), 32'(er));
                check("hold_req_ready", 32'(m_req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check("post_rsp_valid", 32'(m_rsp_valid), 32'd0);
            check("post_rsp_rdata", m_rsp_rdata, 32'd0);
            check("post_rsp_err",   32'(m_rsp_err), 32'd0);
            check("post_req_ready", 32'(m_req_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] rd, mrd, a;
        logic er, mer, wr;
        logic [2:0] sz;

        vt[0]  = '{1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 3'd0, 32'h011, 32'h00000080, 32'h0,        1'b0};
        vt[3]  = '{1'b0, 3'd0, 32'h011, 32'h0,        32'hFFFFFF80, 1'b0};
        vt[4]  = '{1'b0, 3'd4, 32'h011, 32'h0,        32'h00000080, 1'b0};
        vt[5]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'hDEAD80EF, 1'b0};
        vt[6]  = '{1'b1, 3'd1, 32'h012, 32'h00001234, 32'h0,        1'b0};
        vt[7]  = '{1'b0, 3'd1, 32'h012, 32'h0,        32'h00001234, 1'b0};
        vt[8]  = '{1'b0, 3'd2, 32'h010, 32'h0,        32'h123480EF, 1'b0};
        vt[9]  = '{1'b0, 3'd2, 32'h013, 32'h0,        32'h0,        1'b1};
        vt[10] = '{1'b1, 3'd1, 32'h011, 32'hFFFFFFFF, 32'h0,        1'b1};
        vt[11] = '{1'b0, 3'd0, 32'h400, 32'h0,        32'h0,        1'b1};
        vt[12] = '{1'b0, 3'd3, 32'h010, 32'h0,        32'h0,        1'b1};
        vt[13] = '{1'b1, 3'd4, 32'h010, 32'hFFFFFFFF, 32'h0,        1'b1};
        vt[14] = '{1'b0, 3'd2, 32'h010, 32'h0,        32'h123480EF, 1'b0};
        vt[15] = '{1'b0, 3'd5, 32'h010, 32'h0,        32'h000080EF, 1'b0};
        vt[16] = '{1'b0, 3'd1, 32'h010, 32'h0,        32'hFFFF80EF, 1'b0};
        vt[17] = '{1'b1, 3'd2, 32'h3FC, 32'hA5A50001, 32'h0,        1'b0};
        vt[18] = '{1'b0, 3'd2, 32'h3FC, 32'h0,        32'hA5A50001, 1'b0};
        vt[19] = '{1'b1, 3'd2, 32'h020, 32'h0BADF00D, 32'h0,        1'b0};

        rst = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b0;
        #12;
        chk_reset_vals("reset_w2");
        sel = 1'b1; #1;
        chk_reset_vals("reset_w0");
        @(negedge clk);
        rst = 1'b1;

        // Give both instances a defined low region before any loads.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 32; w++) begin
                a = 32'(w * 4);
                model(s, 1'b1, 3'd2, a, $urandom, mrd, mer);
                txn(1'b1, 3'd2, a, {ref_mem[s][w*4+3], ref_mem[s][w*4+2], ref_mem[s][w*4+1],
                    ref_mem[s][w*4]}, 0, 1'b0, exp_lat(s, 1'b0), rd, er);
                check("init_rdata", rd, 32'd0);
            end
        end

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 20; i++) begin
                model(s, vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wd, mrd, mer);
                txn(vt[i].wr, vt[i].sz, vt[i].addr, vt[i].wd, (i == 1) ? 5 : 0, 1'b0,
                    exp_lat(s, vt[i].er), rd, er);
                check($sformatf("vec%0d_w%0d_rdata", i, s), rd, vt[i].rd);
                check($sformatf("vec%0d_w%0d_err", i, s), 32'(er), 32'(vt[i].er));
            end
        end

        // Reset during WAIT of a store: store abandoned, outputs at reset values.
        sel = 1'b0;
        @(negedge clk);
        req_write = 1'b1; req_size = 3'd2; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_wait_busy_before", 32'(m_busy), 32'd1);
        rst = 1'b0; #1;
        chk_reset_vals("rst_wait_async");
        @(posedge clk); #1;
        chk_reset_vals("rst_wait_held");
        @(posedge clk); #1;
        chk_reset_vals("rst_wait_held2");
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, exp_lat(0, 1'b0), rd, er);
        check("rst_wait_lw_rdata", rd, 32'h0BADF00D);
        check("rst_wait_lw_err", 32'(er), 32'd0);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 150; i++) begin
                wr = 1'($urandom_range(0, 1));
                sz = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 9))
                    0:       a = $urandom;
                    1:       a = 32'h3FC + 32'($urandom_range(0, 3));
                    default: a = 32'($urandom_range(0, 127));
                endcase
                rd = $urandom;
                model(s, wr, sz, a, rd, mrd, mer);
                txn(wr, sz, a, rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    exp_lat(s, mer), rd, er);
                check($sformatf("rand_w%0d_rdata a=%h sz=%0d wr=%0d", s, a, sz, wr), rd, mrd);
                check($sformatf("rand_w%0d_err a=%h sz=%0d wr=%0d", s, a, sz, wr),
                      32'(er), 32'(mer));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
